// File: rtl/alu_sched.sv
// Two-requester round-robin scheduler in front of a shared combinational ALU.
// Sequences one operation at a time and expands FDIV into invf(b) then mulf(a, 1/b).
module alu_sched (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_op,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_op,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic [4:0]  alu_op,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    input  logic [15:0] alu_result
);

    // state | meaning
    // IDLE  | arbitrate and accept one request
    // EXEC  | single ALU pass with the latched op
    // DIV1  | FDIV pass 1: invf(b) into tmp
    // DIV2  | FDIV pass 2: mulf(a, tmp)
    // RESP  | hold result until the consumer takes it
    typedef enum logic [2:0] {IDLE, EXEC, DIV1, DIV2, RESP} state_t;

    localparam logic [4:0] FDIV_OP = 5'b10000;
    localparam logic [4:0] OP_INVF = 5'b00001;
    localparam logic [4:0] OP_MULF = 5'b00011;

    state_t      state_q, state_d;
    logic [4:0]  op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] tmp_q, tmp_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        id_q, id_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_sel;

    // With both valid, the requester not granted last wins; otherwise whoever is valid.
    always_comb begin
        grant_sel = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        tmp_d        = tmp_q;
        rsp_data_d   = rsp_data_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        alu_op       = 5'd0;
        alu_in1      = 16'd0;
        alu_in2      = 16'd0;

        case (state_q)
            IDLE: begin
                if (reset_n && (req0_valid || req1_valid)) begin
                    req0_ready   = ~grant_sel;
                    req1_ready   = grant_sel;
                    op_d         = grant_sel ? req1_op : req0_op;
                    a_d          = grant_sel ? req1_a  : req0_a;
                    b_d          = grant_sel ? req1_b  : req0_b;
                    id_d         = grant_sel;
                    last_grant_d = grant_sel;
                    state_d      = (op_d == FDIV_OP) ? DIV1 : EXEC;
                end
            end
            EXEC: begin
                alu_op     = op_q;
                alu_in1    = a_q;
                alu_in2    = b_q;
                rsp_data_d = alu_result;
                state_d    = RESP;
            end
            DIV1: begin
                alu_op  = OP_INVF;
                alu_in1 = b_q;
                tmp_d   = alu_result;
                state_d = DIV2;
            end
            DIV2: begin
                alu_op     = OP_MULF;
                alu_in1    = a_q;
                alu_in2    = tmp_q;
                rsp_data_d = alu_result;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            op_q         <= 5'd0;
            a_q          <= 16'd0;
            b_q          <= 16'd0;
            tmp_q        <= 16'd0;
            rsp_data_q   <= 16'd0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            tmp_q        <= tmp_d;
            rsp_data_q   <= rsp_data_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: a toy ALU model drives alu_result, expected responses are
// queued as requests are accepted and popped by a monitor on each handshake.
module tb_alu_sched;

    logic        clk;
    logic        reset_n;
    logic        req0_valid, req0_ready;
    logic [4:0]  req0_op;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [4:0]  req1_op;
    logic [15:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [15:0] rsp_data;
    logic [4:0]  alu_op;
    logic [15:0] alu_in1, alu_in2, alu_result;

    typedef struct packed {
        logic        id;
        logic [15:0] data;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    alu_sched dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_result(alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Toy float-ish ALU: invf(0x4000)=0x3F00, mulf(0x4000,0x3F00)=0x3F80.
    function automatic logic [15:0] alu_fn(input logic [4:0] op, input logic [15:0] x,
                                           input logic [15:0] y);
        case (op)
            5'd0:    return x + y;
            5'd1:    return (x == 16'd0) ? 16'd0 : 16'h7F00 - x;
            5'd3:    return (x == 16'd0 || y == 16'd0) ? 16'd0 : x + y - 16'h3F80;
            5'd4:    return x & y;
            default: return x ^ {y[7:0], y[15:8]} ^ {11'd0, op};
        endcase
    endfunction

    assign alu_result = alu_fn(alu_op, alu_in1, alu_in2);

    always @(negedge clk) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp got id=%0d data=%h, none expected", rsp_id, rsp_data);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                if (rsp_id !== e.id || rsp_data !== e.data) begin
                    errors++;
                    $display("FAIL rsp_scoreboard got id=%0d data=%h expected id=%0d data=%h",
                             rsp_id, rsp_data, e.id, e.data);
                end
            end
        end
        if (req0_valid && req1_valid) begin
            checks++;
            if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
                errors++;
                $display("FAIL one_hot_ready got both ready expected at most one");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish expected finish before 200us");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        reset_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 5'd4; req0_a = 16'h00FF; req0_b = 16'h0F0F;
        req1_valid = 1'b1; req1_op = 5'd4; req1_a = 16'h00FF; req1_b = 16'h0F0F;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %b%b expected 00", req0_ready, req1_ready);
        end
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_valid got %b expected 0", rsp_valid);
        end
        if (rsp_data !== 16'd0) begin
            errors++; $display("FAIL reset_rsp_data got %h expected 0000", rsp_data);
        end
        if (rsp_id !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_id got %b expected 0", rsp_id);
        end
        if (alu_op !== 5'd0 || alu_in1 !== 16'd0 || alu_in2 !== 16'd0) begin
            errors++;
            $display("FAIL reset_alu got op=%h in1=%h in2=%h expected zeros", alu_op, alu_in1, alu_in2);
        end
        @(posedge clk); #1;
        reset_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_contention();
        int accepts = 0;
        int n = 0;
        logic got;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 5'd4; req0_a = 16'h00FF; req0_b = 16'h0F0F;
        req1_valid = 1'b1; req1_op = 5'd4; req1_a = 16'h00FF; req1_b = 16'h0F0F;
        while (accepts < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                got = req1_ready;
                checks++;
                if (got !== accepts[0]) begin
                    errors++;
                    $display("FAIL contention_grant%0d got %0d expected %0d", accepts, got, accepts[0]);
                end
                exp_q.push_back('{id: accepts[0], data: 16'h000F});
                accepts++;
                if (accepts == 4) begin
                    @(posedge clk); #1;
                    req0_valid = 1'b0; req1_valid = 1'b0;
                end
            end
        end
        checks++;
        if (accepts != 4) begin
            errors++;
            $display("FAIL contention_accepts got %0d expected 4", accepts);
            req0_valid = 1'b0; req1_valid = 1'b0;
        end
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL contention_drain got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_simple_op();
        int n = 0;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 5'd0; req0_a = 16'h0003; req0_b = 16'h0004;
        @(negedge clk);
        while (req0_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++; $display("FAIL simple_grant got %b expected 1", req0_ready);
        end
        exp_q.push_back('{id: 1'b0, data: 16'h0007});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        checks += 2;
        if (alu_op !== 5'd0 || alu_in1 !== 16'h0003 || alu_in2 !== 16'h0004) begin
            errors++;
            $display("FAIL simple_exec got op=%h in1=%h in2=%h expected 00/0003/0004",
                     alu_op, alu_in1, alu_in2);
        end
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL simple_early_valid got %b expected 0", rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 16'h0007) begin
            errors++;
            $display("FAIL simple_rsp got v=%b id=%b data=%h expected 1/0/0007",
                     rsp_valid, rsp_id, rsp_data);
        end
    endtask

    task automatic test_fdiv();
        int n = 0;
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_op = 5'b10000; req1_a = 16'h4000; req1_b = 16'h4000;
        @(negedge clk);
        while (req1_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++; $display("FAIL fdiv_grant got %b expected 1", req1_ready);
        end
        exp_q.push_back('{id: 1'b1, data: alu_fn(5'd3, 16'h4000, alu_fn(5'd1, 16'h4000, 16'd0))});
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (alu_op !== 5'd1 || alu_in1 !== 16'h4000 || alu_in2 !== 16'd0) begin
            errors++;
            $display("FAIL fdiv_pass1 got op=%h in1=%h in2=%h expected 01/4000/0000",
                     alu_op, alu_in1, alu_in2);
        end
        @(negedge clk);
        checks++;
        if (alu_op !== 5'd3 || alu_in1 !== 16'h4000 || alu_in2 !== 16'h3F00) begin
            errors++;
            $display("FAIL fdiv_pass2 got op=%h in1=%h in2=%h expected 03/4000/3F00",
                     alu_op, alu_in1, alu_in2);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 16'h3F80) begin
            errors++;
            $display("FAIL fdiv_rsp got v=%b id=%b data=%h expected 1/1/3F80",
                     rsp_valid, rsp_id, rsp_data);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 5'd0; req0_a = 16'h0010; req0_b = 16'h0020;
        req1_valid = 1'b1; req1_op = 5'd0; req1_a = 16'h0010; req1_b = 16'h0020;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_first_grant got %b%b expected 10", req0_ready, req1_ready);
        end
        exp_q.push_back('{id: 1'b0, data: 16'h0030});
        while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 16'h0030 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b id=%b data=%h rdy=%b%b expected 1/0/0030/00",
                         i, rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready);
            end
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_next_grant got %b%b expected 01", req0_ready, req1_ready);
        end
        exp_q.push_back('{id: 1'b1, data: 16'h0030});
        @(posedge clk); #1;
        req1_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (req0_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++; $display("FAIL bp_third_grant got %b expected 1", req0_ready);
        end
        exp_q.push_back('{id: 1'b0, data: 16'h0030});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_fdiv();
        int n = 0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 5'b10000; req0_a = 16'h4000; req0_b = 16'h4000;
        @(negedge clk);
        while (req0_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (alu_op !== 5'd3) begin
            errors++; $display("FAIL midrst_in_div2 got op=%h expected 03", alu_op);
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        req0_valid = 1'b1; req0_op = 5'd4; req0_a = 16'h00FF; req0_b = 16'h0F0F;
        req1_valid = 1'b1; req1_op = 5'd4; req1_a = 16'h00FF; req1_b = 16'h0F0F;
        @(negedge clk);
        checks += 3;
        if (rsp_valid !== 1'b0 || rsp_data !== 16'd0 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL midrst_rsp got v=%b id=%b data=%h expected 0/0/0000",
                     rsp_valid, rsp_id, rsp_data);
        end
        if (alu_op !== 5'd0 || alu_in1 !== 16'd0 || alu_in2 !== 16'd0) begin
            errors++;
            $display("FAIL midrst_alu got op=%h in1=%h in2=%h expected zeros", alu_op, alu_in1, alu_in2);
        end
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_grant got %b%b expected 10", req0_ready, req1_ready);
        end
        exp_q.push_back('{id: 1'b0, data: 16'h000F});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (req1_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_second_grant got %b expected 1", req1_ready);
        end
        exp_q.push_back('{id: 1'b1, data: 16'h000F});
        @(posedge clk); #1;
        req1_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_drain got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_passthrough();
        int n = 0;
        logic [15:0] exp_data;
        exp_data = alu_fn(5'b01111, 16'h1234, 16'h00AB);
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 5'b01111; req0_a = 16'h1234; req0_b = 16'h00AB;
        @(negedge clk);
        while (req0_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        exp_q.push_back('{id: 1'b0, data: exp_data});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (alu_op !== 5'b01111 || alu_in1 !== 16'h1234 || alu_in2 !== 16'h00AB) begin
            errors++;
            $display("FAIL pass_exec got op=%h in1=%h in2=%h expected 0f/1234/00ab",
                     alu_op, alu_in1, alu_in2);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_data || alu_op !== 5'd0) begin
            errors++;
            $display("FAIL pass_rsp got v=%b data=%h op=%h expected 1/%h/00",
                     rsp_valid, rsp_data, alu_op, exp_data);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pass_drain got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        reset_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_op = 5'd0; req0_a = 16'd0; req0_b = 16'd0;
        req1_valid = 1'b0; req1_op = 5'd0; req1_a = 16'd0; req1_b = 16'd0;
        test_reset();
        test_contention();
        test_simple_op();
        test_fdiv();
        test_backpressure();
        test_reset_mid_fdiv();
        test_passthrough();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
